// File: rtl/tt_pkg.sv
// Shared definitions for the ternary matrix-vector MAC tile.
// Holds the controller state encoding, the ternary weight codes and the
// weight decode used by both the MAC datapath and the weight-load stage.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } w_op_t;

  localparam logic [1:0] W_POS = 2'b01;
  localparam logic [1:0] W_NEG = 2'b11;

  // 2'b00 and 2'b10 both mean zero weight.
  function automatic w_op_t decode_weight(input logic [1:0] code);
    w_op_t op;
    case (code)
      W_POS:   op = OP_ADD;
      W_NEG:   op = OP_SUB;
      default: op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ternary_pe.sv
// One accumulator column of the ternary MAC.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - synchronous clear of the accumulator
//   en        - accumulate this cycle
//   w_code    - 2-bit ternary weight code
//   data      - sign-extended activation
//   acc       - registered accumulator value
module ternary_pe
  import tt_pkg::*;
#(
  parameter int ACC_BITS = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic [1:0]                 w_code,
  input  logic signed [ACC_BITS-1:0] data,
  output logic signed [ACC_BITS-1:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      case (decode_weight(w_code))
        OP_ADD:  acc <= acc + data;
        OP_SUB:  acc <= acc - data;
        default: acc <= acc;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_ternary_mac.sv
// Ternary-weight matrix-vector multiply-accumulate tile.
// Streams in_len activations (one per accepted beat), accumulates each into
// out_len parallel columns using weights of +1/0/-1, then streams out the
// out_len results.
// Ports:
//   clk, rst, ena           - clock, sync active-high reset, tile enable
//   start, cfg_*_len_m1     - run request and minus-one lengths
//   weights                 - packed weight matrix, row-major over columns
//   in_data/valid/ready     - activation stream
//   out_data/valid/ready    - result stream
//   busy, done              - status; done pulses on the final result
module tt_um_ternary_mac
  import tt_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int WIDTH       = 2,
  parameter int IN_BITS     = 8,
  parameter int ACC_BITS    = IN_BITS + $clog2(MAX_IN_LEN) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ena,
  input  logic                                  start,
  input  logic [$clog2(MAX_IN_LEN)-1:0]         cfg_in_len_m1,
  input  logic [$clog2(MAX_OUT_LEN)-1:0]        cfg_out_len_m1,
  input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights,
  input  logic signed [IN_BITS-1:0]             in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic signed [ACC_BITS-1:0]            out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int IL_W = $clog2(MAX_IN_LEN);
  localparam int OL_W = $clog2(MAX_OUT_LEN);

  state_t state, state_next;
  logic [IL_W-1:0] row, in_len_q;
  logic [OL_W-1:0] col, out_len_q;
  logic start_fire, in_fire, out_fire;
  logic signed [ACC_BITS-1:0] data_ext;
  logic signed [ACC_BITS-1:0] acc [MAX_OUT_LEN];
  logic [WIDTH-1:0] wmat [MAX_IN_LEN][MAX_OUT_LEN];

  assign start_fire = (state == IDLE)  && start && ena;
  assign in_fire    = (state == ACCUM) && in_valid && ena;
  assign out_fire   = (state == DRAIN) && out_ready && ena;
  assign data_ext   = {{(ACC_BITS-IN_BITS){in_data[IN_BITS-1]}}, in_data};

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start_fire) state_next = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_fire && (row == in_len_q)) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_fire && (col == out_len_q)) begin
          state_next = IDLE;
          // A reset in the final drain cycle aborts the run, so no done.
          done       = !rst;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      in_len_q  <= '0;
      out_len_q <= '0;
    end else begin
      if (start_fire) begin
        in_len_q  <= cfg_in_len_m1;
        out_len_q <= cfg_out_len_m1;
        row       <= '0;
        col       <= '0;
      end
      if (in_fire)  row <= (row == in_len_q)  ? '0 : row + 1'b1;
      if (out_fire) col <= (col == out_len_q) ? '0 : col + 1'b1;
    end
  end

  assign out_data = (state == DRAIN) ? acc[col] : '0;

  for (genvar i = 0; i < MAX_IN_LEN; i++) begin : g_row
    for (genvar j = 0; j < MAX_OUT_LEN; j++) begin : g_col
      assign wmat[i][j] = weights[(i*MAX_OUT_LEN + j)*WIDTH +: WIDTH];
    end
  end

  for (genvar j = 0; j < MAX_OUT_LEN; j++) begin : g_pe
    logic [WIDTH-1:0] code;
    logic             col_en;
    assign code   = wmat[row][j];
    // Columns beyond the configured length never accumulate, so stay zero.
    assign col_en = in_fire && (OL_W'(j) <= out_len_q);

    ternary_pe #(.ACC_BITS(ACC_BITS)) u_pe (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_fire),
      .en     (col_en),
      .w_code (code[1:0]),
      .data   (data_ext),
      .acc    (acc[j])
    );
  end

endmodule

// File: tb/tb_tt_um_ternary_mac.sv
module tb_tt_um_ternary_mac;
  localparam int MI = 16;
  localparam int MO = 8;
  localparam int W  = 2;
  localparam int IB = 8;
  localparam int AB = 13;
  localparam int WB = $clog2(W*MI*MO);

  logic clk = 1'b0;
  logic rst, ena, start;
  logic [3:0] cfg_in_len_m1;
  logic [2:0] cfg_out_len_m1;
  logic [W*MI*MO-1:0] weights;
  logic signed [IB-1:0] in_data;
  logic in_valid, in_ready;
  logic signed [AB-1:0] out_data;
  logic out_valid, out_ready, busy, done;

  tt_um_ternary_mac #(
    .MAX_IN_LEN(MI), .MAX_OUT_LEN(MO), .WIDTH(W), .IN_BITS(IB)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
    .cfg_in_len_m1(cfg_in_len_m1), .cfg_out_len_m1(cfg_out_len_m1),
    .weights(weights),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wv[MI][MO];
  int xv[MI];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Weight value v in {-1,0,1}; zero uses either of its two codes.
  task automatic set_w(input int i, input int j, input int v);
    logic [1:0] code;
    wv[i][j] = v;
    if (v == 1)       code = 2'b01;
    else if (v == -1) code = 2'b11;
    else              code = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
    weights[WB'((i*MO + j)*W) +: W] = code;
  endtask

  task automatic rand_all();
    for (int i = 0; i < MI; i++)
      for (int j = 0; j < MO; j++)
        set_w(i, j, int'($urandom_range(0, 2)) - 1);
    for (int i = 0; i < MI; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Monitor: pops the scoreboard on every accepted result.
  logic signed [AB-1:0] prev_data;
  bit stall_prev = 1'b0;
  always @(negedge clk) begin
    bit fire;
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      fire = out_valid && out_ready && ena;
      if (stall_prev) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(prev_data));
      end
      if (fire) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", int'(out_data), e.val);
          check("done_on_accept", int'(done), int'(e.last));
        end
      end else if (done) begin
        check("done_without_accept", 1, 0);
      end
      if (done) done_cnt++;
      stall_prev = out_valid && !fire;
      prev_data  = out_data;
    end
  end

  task automatic run_vec(input int il, input int ol, input bit stress, input bit abort);
    int beat, cyc, s;
    bit fire;
    for (int j = 0; j < ol; j++) begin
      s = 0;
      for (int i = 0; i < il; i++) s += wv[i][j] * xv[i];
      sb.push_back('{val: s, last: (j == ol - 1)});
    end
    done_cnt = 0;
    cfg_in_len_m1  = 4'(il - 1);
    cfg_out_len_m1 = 3'(ol - 1);
    start = 1'b1;
    ena   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    beat = 0;
    cyc  = 0;
    while (beat < il && cyc < 1000) begin
      in_data  = IB'(xv[beat]);
      in_valid = stress ? ($urandom_range(0, 1) != 0) : 1'b1;
      ena      = stress ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stress && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        cfg_in_len_m1  = 4'($urandom);
        cfg_out_len_m1 = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      fire = in_valid && in_ready && ena;
      @(posedge clk); #1;
      if (fire) beat++;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    ena      = 1'b1;
    check("input_beats", beat, il);
    check("first_out_valid", int'(out_valid), 1);
    check("in_ready_in_drain", int'(in_ready), 0);
    cyc = 0;
    while (busy && cyc < 1000) begin
      if (abort && cyc == 2) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_data", int'(out_data), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        sb.delete();
        break;
      end
      out_ready = stress ? ((cyc >= 1 && cyc <= 3) ? 1'b0 : ($urandom_range(0, 1) != 0)) : 1'b1;
      ena       = stress ? ($urandom_range(0, 4) != 0) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    ena       = 1'b1;
    @(posedge clk); #1;
    check("drain_finished", int'(busy), 0);
    check("scoreboard_empty", sb.size(), 0);
    check("done_count", done_cnt, abort ? 0 : 1);
  endtask

  initial begin
    int il, ol;
    weights = '0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cfg_in_len_m1 = '0;
    cfg_out_len_m1 = '0;
    rst = 1'b1;
    ena = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;

    // Identity 4x4
    rand_all();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) set_w(i, j, (i == j) ? 1 : 0);
    for (int i = 0; i < 4; i++) xv[i] = i + 1;
    run_vec(4, 4, 1'b0, 1'b0);

    // Negation and zero columns
    rand_all();
    for (int i = 0; i < 3; i++) begin
      set_w(i, 0, -1);
      set_w(i, 1, 0);
    end
    xv[0] = 127; xv[1] = 127; xv[2] = -128;
    run_vec(3, 2, 1'b0, 1'b0);

    // Full size, most negative accumulation
    for (int i = 0; i < MI; i++) begin
      xv[i] = -128;
      for (int j = 0; j < MO; j++) set_w(i, j, 1);
    end
    run_vec(16, 8, 1'b0, 1'b0);

    // Backpressure, ena gaps, start during ACCUM
    rand_all();
    run_vec(16, 8, 1'b1, 1'b0);

    // Reset mid-DRAIN, then the same run again
    rand_all();
    run_vec(5, 8, 1'b0, 1'b1);
    run_vec(5, 8, 1'b0, 1'b0);

    // Minimum lengths
    rand_all();
    run_vec(1, 1, 1'b1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      rand_all();
      il = int'($urandom_range(1, MI));
      ol = int'($urandom_range(1, MO));
      run_vec(il, ol, bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_ternary_mac.md
TT_UM_TERNARY_MAC -- requirements
Module: tt_um_ternary_mac

Interface
REQ-001 SHALL have parameter MAX_IN_LEN, default 16, maximum input-vector length (rows of the weight matrix).
REQ-002 SHALL have parameter MAX_OUT_LEN, default 8, maximum output-vector length (columns).
REQ-003 SHALL have parameter WIDTH, default 2, bits per ternary weight.
REQ-004 SHALL have parameter IN_BITS, default 8, signed activation width.
REQ-005 SHALL have parameter ACC_BITS, default IN_BITS + $clog2(MAX_IN_LEN) + 1, signed accumulator and result width.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port ena, input, 1, tile enable; when low, all state holds and handshakes stall.
REQ-009 SHALL have port start, input, 1, one-cycle request to begin a vector product.
REQ-010 SHALL have port cfg_in_len_m1, input, $clog2(MAX_IN_LEN), input length minus one, sampled on accepted start.
REQ-011 SHALL have port cfg_out_len_m1, input, $clog2(MAX_OUT_LEN), output length minus one, sampled on accepted start.
REQ-012 SHALL have port weights, input, WIDTH*MAX_IN_LEN*MAX_OUT_LEN, the weight matrix from the weight-load stage.
REQ-013 SHALL have ports in_data (input, IN_BITS, signed activation), in_valid (input, 1) and in_ready (output, 1).
REQ-014 SHALL have ports out_data (output, ACC_BITS, signed result), out_valid (output, 1) and out_ready (input, 1).
REQ-015 SHALL have ports busy (output, 1, high outside IDLE) and done (output, 1, one-cycle pulse).

Function
REQ-016 Weight for row i and column j SHALL be the bits at index (i*MAX_OUT_LEN + j)*WIDTH + b, for b = 0..WIDTH-1.
REQ-017 Weight decode SHALL be: 2'b01 = +1, 2'b11 = -1, 2'b00 and 2'b10 = 0.
REQ-018 FSM SHALL have states IDLE, ACCUM and DRAIN.
REQ-019 IDLE -> ACCUM SHALL occur on start&&ena; this latches the cfg fields, clears all accumulators and clears the row and column counters.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 In ACCUM, in_ready SHALL be 1; in_ready SHALL be 0 in IDLE and DRAIN.
REQ-022 In ACCUM, each beat accepted (in_valid&&in_ready&&ena) at row r SHALL update acc[j] += decode(w[r][j]) * in_data for every j <= out_len_m1, all in parallel within one cycle, and SHALL then increment r.
REQ-023 Multiplication SHALL be implemented as add, subtract or hold only; in_data SHALL be sign-extended to ACC_BITS; no overflow is possible at default widths.
REQ-024 Acceptance of the beat at r == in_len_m1 SHALL cause ACCUM -> DRAIN on the next edge, with column counter c = 0.
REQ-025 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal acc[c], driven from registered values.
REQ-026 On out_valid&&out_ready&&ena, c SHALL increment.
REQ-027 Acceptance at c == out_len_m1 SHALL return the FSM to IDLE and pulse done for exactly that cycle.
REQ-028 out_data and out_valid SHALL hold stable while out_ready is low.
REQ-029 Latency: the first out_valid SHALL assert on the cycle after the last input beat is accepted; throughput SHALL be 1 input per cycle and 1 output per cycle.
REQ-030 Weights SHALL be read combinationally and are required stable from start to done; behaviour with changing weights is unspecified.
REQ-031 Accumulators with column index > out_len_m1 SHALL remain zero and SHALL never be output.
REQ-032 Length fields SHALL be treated as minus-one encodings; the minimum length is 1 and the maximum is MAX_*_LEN; no wrap beyond the configured lengths.

Reset
REQ-033 With rst high at a clk edge: FSM = IDLE, all accumulators = 0, counters = 0, in_ready = 0, out_valid = 0, out_data = 0, busy = 0, done = 0; rst SHALL take priority over ena and start.
REQ-034 rst asserted mid-ACCUM or mid-DRAIN SHALL abort without a done pulse; the next start SHALL behave as from power-up.

Structure
REQ-035 Package tt_pkg SHALL hold the state enum, the weight-code constants (W_POS=2'b01, W_NEG=2'b11) and a decode function shared with the weight-load stage.
REQ-036 SHALL instantiate MAX_OUT_LEN copies of sub-module ternary_pe, each holding one accumulator with clear, enable, weight-code, data and acc ports.

Verification
REQ-037 Identity: w[i][i]=+1 with all other weights 0, in=4,4 -> wait, lens 4x4, in=1,2,3,4 -> out=1,2,3,4, then a done pulse.
REQ-038 Negation and zero: column 0 all -1, column 1 all 0, in=[127,127,-128] -> out0=-126, out1=0.
REQ-039 Full size: 16x8, all weights +1, in=-128 for 16 beats -> every out=-2048, no overflow.
REQ-040 Backpressure: in_valid toggled, and out_ready low for 3 cycles mid-DRAIN -> results unchanged, out_data stable while stalled, done pulses once.
REQ-041 Control: start during ACCUM is ignored; rst pulsed during DRAIN -> outputs clear next cycle, no done pulse; a new run yields correct results.
REQ-042 ena low for 2 cycles mid-ACCUM -> no beat is consumed and the final results match the ena-always-high run.
